load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 144 ++++++++++++++
 tb/tb_load_store_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: sign/zero-extending loads and read-modify-write sub-word stores
// against a word-wide data memory, with a GPIO register accessed unmodified.
module load_store_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rw,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [31:0] GPIO_ADDR = 32'h0000_ABCD;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic        err_q, err_d;

  logic        req_gpio, req_err, req_full, accept;
  logic        gpio_q;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val, store_val;

  always_comb begin
    req_gpio = (req_addr == GPIO_ADDR);
    req_err  = (req_size == 2'b11) ||
               (!req_gpio && ((req_size == 2'b01 && req_addr[0]) ||
                              (req_size == 2'b10 && req_addr[1:0] != 2'b00)));
    req_full = req_gpio || (req_size == 2'b10);
    accept   = req_valid && req_ready;
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = req_err;
          // Sub-word stores need the current word first, so they share READ with loads.
          if (req_err)                  state_d = DONE;
          else if (!req_we || !req_full) state_d = READ;
          else                           state_d = WRITE;
        end
      end
      READ: begin
        word_d  = mem_rdata;
        state_d = we_q ? WRITE : DONE;
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gpio_q = (addr_q == GPIO_ADDR);
    case (addr_q[1:0])
      2'd0:    lane_b = word_q[7:0];
      2'd1:    lane_b = word_q[15:8];
      2'd2:    lane_b = word_q[23:16];
      default: lane_b = word_q[31:24];
    endcase
    lane_h    = addr_q[1] ? word_q[31:16] : word_q[15:0];
    load_val  = word_q;
    store_val = wdata_q;
    if (!gpio_q) begin
      case (size_q)
        2'b00: begin
          load_val  = {{24{~uns_q & lane_b[7]}}, lane_b};
          store_val = word_q;
          store_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end
        2'b01: begin
          load_val  = {{16{~uns_q & lane_h[15]}}, lane_h};
          store_val = word_q;
          store_val[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready  = (state_q == IDLE) && !reset;
    resp_valid = (state_q == DONE);
    resp_err   = resp_valid && err_q;
    resp_rdata = (resp_valid && !err_q && !we_q) ? load_val : '0;
    mem_addr   = gpio_q ? addr_q : {addr_q[31:2], 2'b00};
    mem_rw     = (state_q == WRITE) && !reset;
    mem_wdata  = (state_q == WRITE) ? store_val : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-addressed reference memory model, directed
// scenarios, a reset-during-write abort and randomized accesses.
module tb_load_store_unit;

  localparam logic [31:0] GPIO = 32'h0000_ABCD;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, mem_rw;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] dmem [64];
  logic [31:0] gpio_reg;
  logic        bd_we;
  logic [6:0]  bd_idx;
  logic [31:0] bd_val;

  logic [7:0]  ref_bytes [256];
  logic [31:0] ref_gpio;

  int checks = 0;
  int failures = 0;

  load_store_unit dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rw(mem_rw), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  assign mem_rdata = (mem_addr == GPIO) ? gpio_reg : dmem[mem_addr[7:2]];

  always @(posedge clock) begin
    if (bd_we) begin
      if (bd_idx == 7'd64) gpio_reg <= bd_val;
      else                 dmem[bd_idx[5:0]] <= bd_val;
    end else if (mem_rw) begin
      if (mem_addr == GPIO) gpio_reg <= mem_wdata;
      else                  dmem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int idx, input logic [31:0] val);
    @(negedge clock);
    bd_we = 1'b1; bd_idx = 7'(idx); bd_val = val;
    @(posedge clock);
    @(negedge clock);
    bd_we = 1'b0;
    if (idx == 64) ref_gpio = val;
    else for (int i = 0; i < 4; i++) ref_bytes[idx*4 + i] = val[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_word(input int byte_base);
    logic [31:0] w = '0;
    for (int i = 0; i < 4; i++) w |= 32'(ref_bytes[byte_base + i]) << (8*i);
    return w;
  endfunction

  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input string tag, output logic [31:0] rd_out);
    logic        gpio, eerr;
    int          nb, b, elat, enw;
    logic [31:0] erd, ewaddr, ewdata, val;
    int          lat = 0, nw = 0, n = 0;
    logic [31:0] waddr = '0, wd = '0, rd = '0;
    logic        er = 1'b0, busy_ready = 1'b0, leak = 1'b0;

    gpio = (addr == GPIO);
    eerr = (size == 2'd3) ||
           (!gpio && ((size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0)));
    nb = gpio ? 4 : (1 << size);
    b  = int'(addr[7:0]);
    erd = '0; ewaddr = '0; ewdata = '0; enw = 0;
    if (eerr) begin
      elat = 1;
    end else if (!we) begin
      elat = 2;
      if (gpio) val = ref_gpio;
      else begin
        val = '0;
        for (int i = 0; i < nb; i++) val |= 32'(ref_bytes[b + i]) << (8*i);
      end
      if (!uns && nb < 4 && val[8*nb - 1]) val |= 32'hFFFF_FFFF << (8*nb);
      erd = val;
    end else begin
      enw  = 1;
      elat = (nb == 4) ? 2 : 3;
      if (gpio) begin
        ref_gpio = wdata; ewaddr = addr; ewdata = wdata;
      end else begin
        for (int i = 0; i < nb; i++) ref_bytes[b + i] = wdata[8*i +: 8];
        ewaddr = {addr[31:2], 2'b00};
        ewdata = ref_word(b & 252);
      end
    end

    @(negedge clock);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    while (!req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    @(posedge clock);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (k == 1) req_valid = 1'b0;
      if (mem_rw) begin
        nw++; waddr = mem_addr; wd = mem_wdata;
      end
      if (resp_valid) begin
        lat = k; rd = resp_rdata; er = resp_err;
        break;
      end
      if (req_ready) busy_ready = 1'b1;
      if (resp_rdata != '0 || resp_err) leak = 1'b1;
    end
    check({tag, "_latency"}, 32'(lat), 32'(elat));
    check({tag, "_err"}, 32'(er), 32'(eerr));
    check({tag, "_rdata"}, rd, erd);
    check({tag, "_writes"}, 32'(nw), 32'(enw));
    check({tag, "_busy_ready"}, 32'(busy_ready), 32'd0);
    check({tag, "_idle_leak"}, 32'(leak), 32'd0);
    if (enw == 1) begin
      check({tag, "_waddr"}, waddr, ewaddr);
      check({tag, "_wdata"}, wd, ewdata);
    end
    rd_out = rd;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] ra;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = '0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    bd_we = 1'b0; bd_idx = '0; bd_val = '0;
    for (int w = 0; w < 64; w++) set_word(w, $urandom);
    set_word(64, $urandom);

    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_rw", 32'(mem_rw), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);

    set_word(3, 32'h8899_AABB);
    access(1'b0, 2'd2, 1'b0, 32'd12, '0, "ld_w12", rd);
    check("spec_ld_w12", rd, 32'h8899_AABB);
    access(1'b0, 2'd0, 1'b0, 32'd13, '0, "ld_sb13", rd);
    check("spec_ld_sb13", rd, 32'hFFFF_FFAA);
    access(1'b0, 2'd1, 1'b1, 32'd14, '0, "ld_uh14", rd);
    check("spec_ld_uh14", rd, 32'h0000_8899);

    set_word(9, 32'h1122_3344);
    access(1'b1, 2'd0, 1'b0, 32'd37, 32'h0000_005A, "st_b37", rd);
    check("spec_mem9_after_sb", dmem[9], 32'h1122_5A44);
    access(1'b0, 2'd2, 1'b0, 32'd36, '0, "ld_w36", rd);
    check("spec_ld_w36", rd, 32'h1122_5A44);
    access(1'b1, 2'd2, 1'b0, 32'd36, 32'd1114, "st_w36", rd);
    check("spec_mem9_after_sw", dmem[9], 32'h0000_045A);
    access(1'b1, 2'd2, 1'b0, GPIO, 32'hCAFE_F00D, "st_gpio", rd);
    check("spec_gpio_reg", gpio_reg, 32'hCAFE_F00D);
    access(1'b0, 2'd2, 1'b0, 32'd6, '0, "ld_w6_err", rd);

    // Abort a halfword store in its WRITE cycle.
    @(negedge clock);
    req_we = 1'b1; req_size = 2'd1; req_unsigned = 1'b0; req_addr = 32'd42;
    req_wdata = 32'h0000_BEEF; req_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    check("abort_read_ready", 32'(req_ready), 32'd0);
    @(negedge clock);
    check("abort_in_write", 32'(mem_rw), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_rw_forced", 32'(mem_rw), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd1);
    check("abort_mem_unchanged", dmem[10], ref_word(40));
    begin
      logic seen = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clock);
        if (resp_valid) seen = 1'b1;
      end
      check("abort_no_resp", 32'(seen), 32'd0);
    end

    for (int t = 0; t < 60; t++) begin
      ra = ($urandom_range(0, 7) == 0) ? GPIO : 32'($urandom_range(0, 255));
      access(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), ra, $urandom,
             $sformatf("rnd%0d", t), rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
